fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_pkg.sv | 31 +++
 rtl/fetch_skid_buffer.sv | 75 +++++++
 rtl/fetch_unit.sv | 127 ++++++++++++
 tb/tb_fetch_unit.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared CPU definitions for the fetch stage: datapath widths, RV32 major opcodes,
// the canonical NOP encoding and the fetch controller state encoding.
package fetch_unit_pkg;

    localparam int CPU_INST_SIZE = 32;
    localparam int CPU_DATA_SIZE = 32;

    // ADDI x0, x0, 0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [6:0] {
        OPC_LOAD     = 7'h03,
        OPC_MISC_MEM = 7'h0F,
        OPC_OP_IMM   = 7'h13,
        OPC_AUIPC    = 7'h17,
        OPC_STORE    = 7'h23,
        OPC_OP       = 7'h33,
        OPC_LUI      = 7'h37,
        OPC_BRANCH   = 7'h63,
        OPC_JALR     = 7'h67,
        OPC_JAL      = 7'h6F,
        OPC_SYSTEM   = 7'h73
    } t_opcode;

    typedef enum logic [1:0] {
        ST_FETCH   = 2'd0,
        ST_WAIT    = 2'd1,
        ST_DISCARD = 2'd2
    } t_fetch_state;

endpackage

// File: rtl/fetch_skid_buffer.sv
// Two-entry in-order buffer (output slot + skid slot) between instruction memory
// responses and decode, with a flush that empties both slots.
module fetch_skid_buffer #(
    parameter int               WIDTH      = 64,
    parameter logic [WIDTH-1:0] RESET_DATA = '0
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_flush,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_data,
    output logic [1:0]       o_count
);

    logic             out_valid_q, out_valid_d;
    logic             skid_valid_q, skid_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [WIDTH-1:0] skid_data_q, skid_data_d;
    logic             out_free;

    assign out_free = !out_valid_q || i_ready;

    // An older skid entry always moves up before a new response, keeping order.
    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        if (i_flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (out_free) begin
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_data_d   = skid_data_q;
                skid_valid_d = i_valid;
                if (i_valid) begin
                    skid_data_d = i_data;
                end
            end else begin
                out_valid_d = i_valid;
                if (i_valid) begin
                    out_data_d = i_data;
                end
            end
        end else if (i_valid && !skid_valid_q) begin
            skid_valid_d = 1'b1;
            skid_data_d  = i_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= RESET_DATA;
            skid_valid_q <= 1'b0;
            skid_data_q  <= RESET_DATA;
        end else begin
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
        end
    end

    assign o_ready = !skid_valid_q || i_ready;
    assign o_valid = out_valid_q;
    assign o_data  = out_data_q;
    assign o_count = {1'b0, out_valid_q} + {1'b0, skid_valid_q};

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues sequential instruction-memory requests, pairs
// in-order responses with their PC, buffers two entries for decode, handles redirects.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int                   INST_SIZE = CPU_INST_SIZE,
    parameter int                   DATA_SIZE = CPU_DATA_SIZE,
    parameter logic [DATA_SIZE-1:0] RESET_PC  = '0
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    output logic                 o_imem_req,
    output logic [DATA_SIZE-1:0] o_imem_addr,
    input  logic                 i_imem_gnt,
    input  logic                 i_imem_rvalid,
    input  logic [INST_SIZE-1:0] i_imem_rdata,
    input  logic                 i_redirect,
    input  logic [DATA_SIZE-1:0] i_redirect_pc,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [INST_SIZE-1:0] o_instr,
    output t_opcode              o_op,
    output logic [DATA_SIZE-1:0] o_pc,
    output logic                 o_misaligned
);

    t_fetch_state         state_q, state_d;
    logic [DATA_SIZE-1:0] pc_q, pc_d;
    logic [DATA_SIZE-1:0] rsp_pc_q, rsp_pc_d;
    logic [1:0]           inflight_q, inflight_d;
    logic                 misaligned_q, misaligned_d;

    logic                 buf_in_ready;
    logic [1:0]           buf_count;
    logic [INST_SIZE+DATA_SIZE-1:0] buf_out_data;
    logic [DATA_SIZE-1:0] redirect_aligned;
    logic [2:0]           occupancy;
    logic                 grant;
    logic                 drain;
    logic                 rsp_valid;
    logic                 rsp_accept;

    assign redirect_aligned = {i_redirect_pc[DATA_SIZE-1:2], 2'b00};
    assign grant            = o_imem_req && i_imem_gnt;
    assign drain            = o_valid && i_ready;

    // A slot being drained this cycle is credited so a steady stream never stalls.
    assign occupancy  = 3'(buf_count) + 3'(inflight_q) - 3'(drain);
    assign o_imem_req = !i_rst && !i_redirect && (state_q != ST_DISCARD)
                        && (occupancy < 3'd2);
    assign o_imem_addr = pc_q;

    assign rsp_valid  = i_imem_rvalid && (inflight_q != 2'd0);
    assign rsp_accept = rsp_valid && !i_redirect && (state_q != ST_DISCARD)
                        && buf_in_ready;

    // Responses return in order and fetch is sequential between redirects,
    // so the next response's PC is just the previous one plus 4.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        rsp_pc_d     = rsp_pc_q;
        inflight_d   = inflight_q;
        misaligned_d = i_redirect && (i_redirect_pc[1:0] != 2'b00);
        if (i_redirect) begin
            pc_d       = redirect_aligned;
            rsp_pc_d   = redirect_aligned;
            inflight_d = inflight_q - {1'b0, rsp_valid};
            state_d    = (inflight_d != 2'd0) ? ST_DISCARD : ST_FETCH;
        end else begin
            if (grant) begin
                pc_d = pc_q + DATA_SIZE'(4);
            end
            if (rsp_accept) begin
                rsp_pc_d = rsp_pc_q + DATA_SIZE'(4);
            end
            inflight_d = inflight_q + {1'b0, grant} - {1'b0, rsp_valid};
            case (state_q)
                ST_FETCH, ST_WAIT: state_d = (inflight_d != 2'd0) ? ST_WAIT : ST_FETCH;
                ST_DISCARD:        state_d = (inflight_d != 2'd0) ? ST_DISCARD : ST_FETCH;
                default:           state_d = ST_FETCH;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= ST_FETCH;
            pc_q         <= RESET_PC;
            rsp_pc_q     <= RESET_PC;
            inflight_q   <= 2'd0;
            misaligned_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            rsp_pc_q     <= rsp_pc_d;
            inflight_q   <= inflight_d;
            misaligned_q <= misaligned_d;
        end
    end

    fetch_skid_buffer #(
        .WIDTH      (INST_SIZE + DATA_SIZE),
        .RESET_DATA ({INST_SIZE'(NOP_INSTR), RESET_PC})
    ) u_skid (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_flush (i_redirect),
        .i_valid (rsp_accept),
        .o_ready (buf_in_ready),
        .i_data  ({i_imem_rdata, rsp_pc_q}),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_data  (buf_out_data),
        .o_count (buf_count)
    );

    assign o_instr      = buf_out_data[DATA_SIZE +: INST_SIZE];
    assign o_pc         = buf_out_data[DATA_SIZE-1:0];
    assign o_op         = t_opcode'(o_instr[6:0]);
    assign o_misaligned = misaligned_q;

    // A response with nothing outstanding points at a broken memory model.
    assert property (@(posedge i_clk) disable iff (i_rst)
        !(i_imem_rvalid && (inflight_q == 2'd0)));

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a simple in-order memory model drives the
// request/response side and a scoreboard of expected {pc, instr} checks decode output.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } ExpItem;

    typedef struct packed {
        logic [31:0] due;
        logic [31:0] addr;
    } MemItem;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        o_imem_req;
    logic [31:0] o_imem_addr;
    logic        i_imem_gnt;
    logic        i_imem_rvalid;
    logic [31:0] i_imem_rdata;
    logic        i_redirect;
    logic [31:0] i_redirect_pc;
    logic        o_valid;
    logic        i_ready;
    logic [31:0] o_instr;
    t_opcode     o_op;
    logic [31:0] o_pc;
    logic        o_misaligned;

    always #5 i_clk = ~i_clk;

    fetch_unit #(
        .INST_SIZE (32),
        .DATA_SIZE (32),
        .RESET_PC  (RESET_PC)
    ) dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .o_imem_req    (o_imem_req),
        .o_imem_addr   (o_imem_addr),
        .i_imem_gnt    (i_imem_gnt),
        .i_imem_rvalid (i_imem_rvalid),
        .i_imem_rdata  (i_imem_rdata),
        .i_redirect    (i_redirect),
        .i_redirect_pc (i_redirect_pc),
        .o_valid       (o_valid),
        .i_ready       (i_ready),
        .o_instr       (o_instr),
        .o_op          (o_op),
        .o_pc          (o_pc),
        .o_misaligned  (o_misaligned)
    );

    int          errorCount = 0;
    int          checkCount = 0;
    int          cycleCount = 0;
    int          gntPct     = 100;
    int          readyPct   = 100;
    int          memLatMin  = 1;
    int          memLatMax  = 1;
    logic [31:0] lastDue    = '0;
    logic        rstCtl     = 1'b1;
    logic        streamCheck = 1'b0;
    logic        expMis     = 1'b0;
    logic        holdPending = 1'b0;
    logic        reqPending = 1'b0;
    logic [31:0] heldPc, heldInstr;
    logic [31:0] expAddr    = RESET_PC;
    ExpItem      expQueue[$];
    MemItem      memQueue[$];

    function automatic logic [31:0] memData(input logic [31:0] addr);
        return {addr[29:0], 2'b11} ^ 32'h5A00_0000;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", tag, observed,
                     expected, cycleCount);
        end
    endtask

    // One clock cycle: drive inputs after the falling edge, then check and model.
    task automatic applyStimulus(input logic redirect, input logic [31:0] target);
        MemItem      m;
        ExpItem      e;
        logic [31:0] due;
        @(negedge i_clk);
        cycleCount++;
        i_rst         = rstCtl;
        i_imem_rvalid = 1'b0;
        i_imem_rdata  = '0;
        if (memQueue.size() > 0 && memQueue[0].due <= 32'(cycleCount)) begin
            m             = memQueue.pop_front();
            i_imem_rvalid = 1'b1;
            i_imem_rdata  = memData(m.addr);
        end
        i_imem_gnt    = ($urandom_range(99) < gntPct);
        i_ready       = ($urandom_range(99) < readyPct);
        i_redirect    = redirect;
        i_redirect_pc = target;
        #1;
        if (rstCtl) begin
            expMis      = 1'b0;
            holdPending = 1'b0;
            reqPending  = 1'b0;
        end else begin
            checkOutput("misaligned", {31'b0, o_misaligned}, {31'b0, expMis});
            if (expQueue.size() == 0)
                checkOutput("valid_empty", {31'b0, o_valid}, 32'd0);
            if (streamCheck)
                checkOutput("thru", {31'b0, o_valid}, 32'd1);
            if (holdPending) begin
                checkOutput("hold_valid", {31'b0, o_valid}, 32'd1);
                checkOutput("hold_pc", o_pc, heldPc);
                checkOutput("hold_instr", o_instr, heldInstr);
            end
            if (redirect)
                checkOutput("redir_req", {31'b0, o_imem_req}, 32'd0);
            else if (reqPending)
                checkOutput("req_hold", {31'b0, o_imem_req}, 32'd1);
            if (o_imem_req) begin
                checkOutput("addr", o_imem_addr, expAddr);
                checkOutput("occ", 32'(expQueue.size() - ((o_valid && i_ready) ? 1 : 0) < 2),
                            32'd1);
            end
            if (o_valid && i_ready && expQueue.size() > 0) begin
                e = expQueue.pop_front();
                checkOutput("pc", o_pc, e.pc);
                checkOutput("instr", o_instr, e.instr);
                checkOutput("op", {25'b0, o_op}, {25'b0, e.instr[6:0]});
            end
            if (redirect) begin
                expQueue.delete();
                expAddr = {target[31:2], 2'b00};
            end else if (o_imem_req && i_imem_gnt) begin
                expQueue.push_back('{pc: expAddr, instr: memData(expAddr)});
                due = 32'(cycleCount + $urandom_range(memLatMax, memLatMin));
                if (due < lastDue) due = lastDue;
                lastDue = due;
                memQueue.push_back('{due: due, addr: o_imem_addr});
                expAddr = expAddr + 32'd4;
            end
            holdPending = o_valid && !i_ready && !redirect;
            heldPc      = o_pc;
            heldInstr   = o_instr;
            reqPending  = o_imem_req && !i_imem_gnt;
            expMis      = redirect && (target[1:0] != 2'b00);
        end
    endtask

    task automatic doReset(input int cycles);
        rstCtl = 1'b1;
        for (int i = 0; i < cycles; i++) applyStimulus(1'b0, '0);
        checkOutput("rst_req", {31'b0, o_imem_req}, 32'd0);
        checkOutput("rst_valid", {31'b0, o_valid}, 32'd0);
        checkOutput("rst_mis", {31'b0, o_misaligned}, 32'd0);
        checkOutput("rst_instr", o_instr, NOP_INSTR);
        checkOutput("rst_pc", o_pc, RESET_PC);
        memQueue.delete();
        expQueue.delete();
        expAddr = RESET_PC;
        lastDue = '0;
        rstCtl  = 1'b0;
        applyStimulus(1'b0, '0);
        checkOutput("rst_first_req", {31'b0, o_imem_req}, 32'd1);
    endtask

    initial begin
        i_rst         = 1'b1;
        i_imem_gnt    = 1'b0;
        i_imem_rvalid = 1'b0;
        i_imem_rdata  = '0;
        i_redirect    = 1'b0;
        i_redirect_pc = '0;
        i_ready       = 1'b0;

        doReset(3);
        applyStimulus(1'b0, '0);
        streamCheck = 1'b1;
        for (int i = 0; i < 20; i++) applyStimulus(1'b0, '0);
        streamCheck = 1'b0;

        readyPct = 0;
        applyStimulus(1'b0, '0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, '0);
            checkOutput("stall_req", {31'b0, o_imem_req}, 32'd0);
        end
        readyPct = 100;
        for (int i = 0; i < 8; i++) applyStimulus(1'b0, '0);

        memLatMin = 3;
        memLatMax = 3;
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, '0);
        applyStimulus(1'b1, 32'h0000_0100);
        memLatMin = 1;
        memLatMax = 1;
        for (int i = 0; i < 12; i++) applyStimulus(1'b0, '0);

        applyStimulus(1'b1, 32'h0000_0102);
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, '0);

        applyStimulus(1'b1, 32'hFFFF_FFF8);
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, '0);

        gntPct    = 60;
        readyPct  = 70;
        memLatMax = 3;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(39) == 0)
                applyStimulus(1'b1, $urandom & 32'h0000_FFFF);
            else
                applyStimulus(1'b0, '0);
        end

        gntPct    = 100;
        readyPct  = 100;
        memLatMin = 3;
        memLatMax = 3;
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, '0);
        doReset(3);
        memLatMin = 1;
        memLatMax = 1;
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, '0);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
